// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - in-order read/write request sequencer for the single-port memory
// Commands queue in a small FIFO and go out as one-cycle memory strobes; one read in flight at a time.
module mem_req_sequencer #(
   parameter int ADDR_W    = 6,
   parameter int DATA_W    = 8,
   parameter int CMD_DEPTH = 4,
   parameter int RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic              mem_rd_en,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   localparam int PW    = $clog2(CMD_DEPTH);
   localparam int PTR_W = PW + 1;
   localparam int EW    = 1 + ADDR_W + DATA_W;
   localparam int CW    = $clog2(RD_LAT + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE_WR = 3'd1;
   localparam logic [2:0] S_ISSUE_RD = 3'd2;
   localparam logic [2:0] S_WAIT_RD  = 3'd3;
   localparam logic [2:0] S_RESP     = 3'd4;

   logic [EW-1:0]    fifo_mem [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [2:0]       state, state_n;
   logic [CW-1:0]    lat_cnt;
   logic [EW-1:0]    head;
   logic             push, pop, lat_done, issue_slot, full_n;

   assign head       = fifo_mem[rd_ptr[PW-1:0]];
   assign push       = req_valid && req_ready;
   assign lat_done   = (state == S_WAIT_RD) && (lat_cnt == CW'(RD_LAT));
   assign issue_slot = (state == S_IDLE) || (state == S_ISSUE_WR) ||
                       ((state == S_RESP) && rsp_ready);
   assign pop        = (wr_ptr != rd_ptr) && issue_slot;
   assign wr_ptr_n   = wr_ptr + PTR_W'(push);
   assign rd_ptr_n   = rd_ptr + PTR_W'(pop);
   assign full_n     = (wr_ptr_n[PW] != rd_ptr_n[PW]) &&
                       (wr_ptr_n[PW-1:0] == rd_ptr_n[PW-1:0]);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= {req_we, req_addr, req_wdata};
   end

   // A pop always overrides the default transition, which is what gives back-to-back issue.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:     state_n = S_IDLE;
         S_ISSUE_WR: state_n = S_IDLE;
         S_ISSUE_RD: state_n = S_WAIT_RD;
         S_WAIT_RD:  if (lat_done) state_n = S_RESP;
         S_RESP:     if (rsp_ready) state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
      if (pop) state_n = head[EW-1] ? S_ISSUE_WR : S_ISSUE_RD;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         lat_cnt   <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         mem_wr_en <= 1'b0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_n;
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         req_ready <= !full_n;
         busy      <= (wr_ptr_n != rd_ptr_n) || (state_n != S_IDLE);
         mem_wr_en <= pop && head[EW-1];
         mem_rd_en <= pop && !head[EW-1];
         if (pop) begin
            mem_addr <= head[EW-2 -: ADDR_W];
            if (head[EW-1]) mem_wdata <= head[DATA_W-1:0];
         end
         // Counter sits at 1 outside WAIT_RD so the first wait cycle already counts.
         lat_cnt <= (state == S_WAIT_RD) ? lat_cnt + CW'(1) : CW'(1);
         if (lat_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_rdata;
         end else if ((state == S_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb/tb_mem_req_sequencer.sv - self-checking bench for mem_req_sequencer
// Transaction-level model plus directed literal checks; a stub memory answers the strobes.
module tb_mem_req_sequencer;
   localparam int ADDR_W    = 6;
   localparam int DATA_W    = 8;
   localparam int CMD_DEPTH = 4;
   localparam int RD_LAT    = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr_en, mem_rd_en;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = 8'hEE;
   logic              busy;

   mem_req_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Stub memory: read data is only valid around the edge ending cycle T+RD_LAT.
   logic [DATA_W-1:0] stub [64];
   logic              rd_hist [RD_LAT+1];
   logic [ADDR_W-1:0] addr_hist [RD_LAT+1];
   initial begin
      for (int i = 0; i < 64; i++) stub[i] = 8'(i * 5 + 3);
      for (int i = 0; i <= RD_LAT; i++) begin rd_hist[i] = 1'b0; addr_hist[i] = '0; end
      forever begin
         @(negedge clk);
         for (int i = RD_LAT; i > 0; i--) begin
            rd_hist[i] = rd_hist[i-1];
            addr_hist[i] = addr_hist[i-1];
         end
         rd_hist[0] = mem_rd_en;
         addr_hist[0] = mem_addr;
         mem_rdata = rd_hist[RD_LAT] ? stub[addr_hist[RD_LAT]] : 8'hEE;
         if (mem_wr_en) stub[mem_addr] = mem_wdata;
      end
   end

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   cmd_t              q[$];
   logic [DATA_W-1:0] mmem [64];
   logic              e_ready = 1'b1, e_busy = 1'b0, e_wr = 1'b0, e_rd = 1'b0, e_rv = 1'b0;
   logic              rd_inflight = 1'b0;
   logic [ADDR_W-1:0] e_addr = '0, rd_addr = '0;
   logic [DATA_W-1:0] e_wdata = '0, e_rdata = '0;
   int                cyc = 0, rd_cyc = 0;

   task automatic model_step();
      logic hs, can_push;
      cmd_t c, nc;
      if (!reset) begin
         q.delete();
         e_ready = 1'b1; e_busy = 1'b0; e_wr = 1'b0; e_rd = 1'b0; e_rv = 1'b0;
         e_addr = '0; e_wdata = '0; e_rdata = '0; rd_inflight = 1'b0; cyc = 0;
      end else begin
         hs = e_rv && rsp_ready;
         can_push = req_valid && (q.size() < CMD_DEPTH);
         if (hs) begin
            e_rv = 1'b0;
            rd_inflight = 1'b0;
         end else if (rd_inflight && !e_rv && cyc == rd_cyc + RD_LAT) begin
            e_rv = 1'b1;
            e_rdata = mmem[rd_addr];
         end
         e_wr = 1'b0;
         e_rd = 1'b0;
         if (!rd_inflight && q.size() > 0) begin
            c = q.pop_front();
            e_addr = c.addr;
            if (c.we) begin
               e_wr = 1'b1; e_wdata = c.data; mmem[c.addr] = c.data;
            end else begin
               e_rd = 1'b1; rd_inflight = 1'b1; rd_cyc = cyc + 1; rd_addr = c.addr;
            end
         end
         if (can_push) begin
            nc.we = req_we; nc.addr = req_addr; nc.data = req_wdata;
            q.push_back(nc);
         end
         e_ready = q.size() < CMD_DEPTH;
         e_busy = (q.size() > 0) || rd_inflight || e_wr || e_rd;
         cyc++;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mmem[i] = 8'(i * 5 + 3);
      forever begin
         @(posedge clk or negedge reset);
         model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (reset && chk_en) begin
         check("cyc_req_ready", req_ready, e_ready);
         check("cyc_busy", busy, e_busy);
         check("cyc_wr_en", mem_wr_en, e_wr);
         check("cyc_rd_en", mem_rd_en, e_rd);
         check("cyc_addr", mem_addr, e_addr);
         check("cyc_wdata", mem_wdata, e_wdata);
         check("cyc_rsp_valid", rsp_valid, e_rv);
         check("cyc_rsp_rdata", rsp_rdata, e_rdata);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   int n_wr_acc = 0;

   task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int guard = 0;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
      check("req_accept", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name);
      int g = 0;
      while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
      check(name, rsp_valid, 1);
   endtask

   task automatic drain(input string name);
      int g = 0;
      while (busy && g < 200) begin @(negedge clk); g++; end
      check(name, busy, 0);
   endtask

   task automatic reset_state(input string name);
      check({name, "_rsp_valid"}, rsp_valid, 0);
      check({name, "_rsp_rdata"}, rsp_rdata, 0);
      check({name, "_wr_en"}, mem_wr_en, 0);
      check({name, "_rd_en"}, mem_rd_en, 0);
      check({name, "_addr"}, mem_addr, 0);
      check({name, "_wdata"}, mem_wdata, 0);
      check({name, "_busy"}, busy, 0);
   endtask

   initial begin
      int g;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      reset_state("rst");
      reset = 1'b1;
      chk_en = 1'b1;

      // 1: single write, strobe two edges after acceptance
      send(1'b1, 6'h05, 8'hA5);
      @(negedge clk);
      check("t1_wr_en", mem_wr_en, 1);
      check("t1_addr", mem_addr, 6'h05);
      check("t1_wdata", mem_wdata, 8'hA5);
      check("t1_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      check("t1_wr_pulse", mem_wr_en, 0);

      // 2: read back, response RD_LAT+1 cycles after rd_en
      rsp_ready = 1'b1;
      send(1'b0, 6'h05, 8'h00);
      @(negedge clk);
      check("t2_rd_en", mem_rd_en, 1);
      check("t2_addr", mem_addr, 6'h05);
      @(negedge clk);
      check("t2_rd_pulse", mem_rd_en, 0);
      check("t2_rsp_early", rsp_valid, 0);
      @(negedge clk);
      check("t2_rsp_valid", rsp_valid, 1);
      check("t2_rsp_rdata", rsp_rdata, 8'hA5);
      @(negedge clk);
      check("t2_rsp_drop", rsp_valid, 0);

      // 3: six writes stalled behind an unconsumed read
      rsp_ready = 1'b0;
      send(1'b0, 6'h05, 8'h00);
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               send(1'b1, 6'(i), 8'(8'h10 + i));
               n_wr_acc++;
            end
         end
         begin
            repeat (12) @(negedge clk);
            check("t3_accepts", n_wr_acc, 4);
            check("t3_ready_low", req_ready, 0);
            check("t3_rsp_rdata", rsp_rdata, 8'hA5);
            rsp_ready = 1'b1;
            g = 0;
            while (!mem_wr_en && g < 20) begin @(negedge clk); g++; end
            for (int i = 0; i < 6; i++) begin
               check("t3_wr_en", mem_wr_en, 1);
               check("t3_addr", mem_addr, i);
               check("t3_wdata", mem_wdata, 8'h10 + i);
               @(negedge clk);
            end
         end
      join
      drain("t3_drain");

      // 4: response held stable while the consumer stalls
      rsp_ready = 1'b0;
      send(1'b0, 6'h05, 8'h00);
      send(1'b1, 6'h07, 8'h77);
      wait_rsp("t4_rsp_seen");
      for (int i = 0; i < 5; i++) begin
         check("t4_rsp_valid", rsp_valid, 1);
         check("t4_rsp_rdata", rsp_rdata, 8'h15);
         check("t4_no_wr", mem_wr_en, 0);
         check("t4_no_rd", mem_rd_en, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_next_wr", mem_wr_en, 1);
      check("t4_next_addr", mem_addr, 6'h07);
      check("t4_rsp_drop", rsp_valid, 0);
      drain("t4_drain");

      // 5: top address, then enough commands to wrap the FIFO pointers
      send(1'b1, 6'h3F, 8'h3C);
      send(1'b0, 6'h3F, 8'h00);
      wait_rsp("t5_rsp_seen");
      check("t5_top_rdata", rsp_rdata, 8'h3C);
      for (int i = 0; i < 12; i++) begin
         if (i % 3 == 2) send(1'b0, 6'(32 + i - 1), 8'h00);
         else            send(1'b1, 6'(32 + i), 8'(i * 7 + 1));
      end
      drain("t5_drain");

      // 6: reset asserted during WAIT_RD with three commands queued
      rsp_ready = 1'b0;
      send(1'b0, 6'h05, 8'h00);
      send(1'b0, 6'h20, 8'h00);
      send(1'b1, 6'h30, 8'h01);
      send(1'b1, 6'h31, 8'h02);
      send(1'b1, 6'h32, 8'h03);
      wait_rsp("t6_rspA");
      rsp_ready = 1'b1;
      g = 0;
      while (!mem_rd_en && g < 20) begin @(negedge clk); g++; end
      check("t6_rdB", mem_rd_en, 1);
      rsp_ready = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1 reset_state("t6_async");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t6_quiet_wr", mem_wr_en, 0);
         check("t6_quiet_rd", mem_rd_en, 0);
         check("t6_quiet_busy", busy, 0);
         check("t6_ready", req_ready, 1);
      end
      send(1'b1, 6'h11, 8'h99);
      @(negedge clk);
      check("t6_post_wr", mem_wr_en, 1);
      check("t6_post_addr", mem_addr, 6'h11);
      drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
